// File: rtl/des_sbox_unit_pkg.sv
// Shared definitions for the registered DES S-box substitution unit:
// the S1..S8 tables, the 6-bit address mapping and the FSM state type.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row-major FIPS 46-3 tables; entry [box][row*16+col], box 1 is S1.
    localparam logic [1:8][0:63][3:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [5:0] sbox_index(input logic [5:0] x, input logic fips);
        logic [5:0] idx;
        if (fips) begin
            idx = {x[5], x[0], x[4:1]};
        end else begin
            idx = x;
        end
        return idx;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Combinational 6->4 lookup into one of S1..S8 (box_sel 0 selects S1).
module des_sbox_lut
    import des_pkg::*;
#(
    parameter int FIPS_ADDR = 1
) (
    input  logic [2:0] box_sel,
    input  logic [5:0] x,
    output logic [3:0] y
);

    logic [5:0] idx_s;

    // Address mapping followed by table select.
    always_comb begin
        idx_s = sbox_index(x, FIPS_ADDR != 0);
        case (box_sel)
            3'd0:    y = SBOX[1][idx_s];
            3'd1:    y = SBOX[2][idx_s];
            3'd2:    y = SBOX[3][idx_s];
            3'd3:    y = SBOX[4][idx_s];
            3'd4:    y = SBOX[5][idx_s];
            3'd5:    y = SBOX[6][idx_s];
            3'd6:    y = SBOX[7][idx_s];
            3'd7:    y = SBOX[8][idx_s];
            default: y = 4'h0;
        endcase
    end

endmodule

// File: rtl/des_sbox_unit.sv
// Registered DES S-box layer: 48-bit word in, 32-bit word out, LANES boxes
// evaluated per cycle over 8/LANES cycles, valid/ready on both sides.
module des_sbox_unit
    import des_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int FIPS_ADDR = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STEPS = 8 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LW    = 6 * LANES;
    localparam int RW    = 4 * LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
    end

    state_e             state_r, state_next_s;
    logic [CNT_W-1:0]   step_r;
    logic [47:0]        work_r;
    logic [31:0]        acc_r;
    logic [TAG_W-1:0]   tag_r;
    logic               out_valid_r;
    logic [31:0]        out_data_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic               in_ready_s;
    logic               accept_s;
    logic               last_step_s;
    logic [RW-1:0]      step_res_s;
    logic [31:0]        acc_next_s;

    // Lane i serves box step*LANES+i from the top of the work register.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [2:0] sel_s;
        assign sel_s = 3'((int'(step_r) * LANES) + i);
        des_sbox_lut #(.FIPS_ADDR(FIPS_ADDR)) u_lut (
            .box_sel (sel_s),
            .x       (work_r[47-6*i -: 6]),
            .y       (step_res_s[RW-1-4*i -: 4])
        );
    end

    assign last_step_s = (step_r == CNT_W'(STEPS - 1));
    assign acc_next_s  = (acc_r << RW) | 32'(step_res_s);
    assign accept_s    = in_valid & in_ready_s;

    // Next-state and input-ready decode.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) state_next_s = BUSY;
                else          state_next_s = IDLE;
            end
            BUSY: begin
                if (last_step_s) state_next_s = DONE;
                else             state_next_s = BUSY;
            end
            DONE: begin
                in_ready_s = out_ready;
                if (out_ready) state_next_s = in_valid ? BUSY : IDLE;
                else           state_next_s = DONE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Work, accumulator, tag and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= 48'h0;
            acc_r  <= 32'h0;
            tag_r  <= '0;
            step_r <= '0;
        end else if (accept_s) begin
            work_r <= in_data;
            acc_r  <= 32'h0;
            tag_r  <= in_tag;
            step_r <= '0;
        end else if (state_r == BUSY) begin
            work_r <= work_r << LW;
            acc_r  <= acc_next_s;
            step_r <= last_step_s ? '0 : step_r + CNT_W'(1);
        end
    end

    // Result registers hold the last result until the next one is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0;
            out_tag_r   <= '0;
        end else if (state_r == BUSY && last_step_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= acc_next_s;
            out_tag_r   <= tag_r;
        end else if (state_r == DONE && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_des_sbox_unit.sv
// Self-checking bench for des_sbox_unit: five instances (LANES 8/4/2/1 in
// FIPS mode, LANES 8 in linear mode), directed steps then random traffic.
module tb_des_sbox_unit;

    localparam int NI = 5;

    // S1..S8, 64 entries each, row-major, first entry in the top nibble.
    localparam logic [255:0] TB_S [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   iv, ir, ov, orr;
    logic [47:0]     id [NI];
    logic [3:0]      it [NI];
    logic [31:0]     od [NI];
    logic [3:0]      ot [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 1) ? 4 : (g == 2) ? 2 : (g == 3) ? 1 : 8;
        localparam int F = (g == 4) ? 0 : 1;
        des_sbox_unit #(.LANES(L), .FIPS_ADDR(F), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .in_tag    (it[g]),
            .out_valid (ov[g]),
            .out_ready (orr[g]),
            .out_data  (od[g]),
            .out_tag   (ot[g])
        );
    end

    function automatic int lanes_of(input int k);
        return (k == 1) ? 4 : (k == 2) ? 2 : (k == 3) ? 1 : 8;
    endfunction

    function automatic bit fips_of(input int k);
        return (k != 4);
    endfunction

    // Reference substitution computed straight from the row/column rules.
    function automatic logic [31:0] ref_sub(input logic [47:0] d, input bit fips);
        logic [31:0] r;
        int x, idx;
        r = 32'h0;
        for (int b = 0; b < 8; b++) begin
            x = int'(d >> (42 - 6 * b)) & 63;
            if (fips) idx = (((x >> 5) & 1) * 2 + (x & 1)) * 16 + ((x >> 1) & 15);
            else      idx = x;
            r = (r << 4) | 32'((TB_S[b] >> (4 * (63 - idx))) & 256'hF);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One word through instance k; optionally consume the result afterwards.
    task automatic run_word(input int k, input logic [47:0] d, input logic [3:0] t, input bit consume);
        int st;
        logic [31:0] expd;
        st = 8 / lanes_of(k);
        expd = ref_sub(d, fips_of(k));
        id[k] = d; it[k] = t; iv[k] = 1'b1; orr[k] = 1'b0;
        #1;
        chk("ready_idle", k, ir[k], 1);
        step();
        iv[k] = 1'b0; id[k] = ~d; it[k] = ~t;
        for (int i = 1; i <= st; i++) begin
            chk("busy_no_valid", k, ov[k], 0);
            chk("busy_not_ready", k, ir[k], 0);
            step();
        end
        chk("valid_latency", k, ov[k], 1);
        chk("data", k, od[k], expd);
        chk("tag", k, ot[k], t);
        if (consume) begin
            orr[k] = 1'b1;
            step();
            orr[k] = 1'b0;
            chk("valid_drop", k, ov[k], 0);
            chk("data_kept", k, od[k], expd);
            chk("tag_kept", k, ot[k], t);
        end
    endtask

    initial begin
        logic [47:0] d1, d2;
        logic [3:0]  t1, t2;
        logic [31:0] e1;
        logic [31:0] q_d [$];
        logic [3:0]  q_t [$];
        logic [31:0] pd;
        logic [3:0]  pt;
        int pushed, popped;

        rst_n = 1'b0;
        iv = '0; orr = '0;
        for (int k = 0; k < NI; k++) begin
            id[k] = 48'h0; it[k] = 4'h0;
        end
        step(); step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NI; k++) begin
            chk("rst_valid", k, ov[k], 0);
            chk("rst_data", k, od[k], 0);
            chk("rst_tag", k, ot[k], 0);
            chk("rst_ready", k, ir[k], 1);
        end

        // All-zero word, single-cycle latency, tag echo.
        run_word(0, 48'h0, 4'h5, 1'b1);
        chk("zero_const", 0, od[0], 32'hEFA72C4D);

        // All-ones word through two lanes.
        run_word(2, 48'hFFFF_FFFF_FFFF, 4'hA, 1'b1);
        chk("ones_const", 2, od[2], 32'hD9CE3DCB);

        // Addressing modes on the S1 chunk.
        run_word(0, {6'b011011, 42'h0}, 4'h3, 1'b1);
        chk("s1_fips_row1col13", 0, od[0][31:28], 4'h5);
        run_word(4, {6'b000001, 42'h0}, 4'h7, 1'b1);
        chk("s1_linear_idx1", 4, od[4][31:28], 4'h4);
        run_word(0, {6'b000001, 42'h0}, 4'h8, 1'b1);
        chk("s1_fips_idx1", 0, od[0][31:28], 4'h0);

        // Back-pressure in DONE, then back-to-back accept.
        d1 = {16'($urandom), $urandom}; t1 = 4'h9;
        d2 = {16'($urandom), $urandom}; t2 = 4'h6;
        e1 = ref_sub(d1, 1'b1);
        run_word(1, d1, t1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 1, ov[1], 1);
            chk("hold_data", 1, od[1], e1);
            chk("hold_tag", 1, ot[1], t1);
            chk("hold_not_ready", 1, ir[1], 0);
        end
        orr[1] = 1'b1; iv[1] = 1'b1; id[1] = d2; it[1] = t2;
        #1;
        chk("b2b_ready", 1, ir[1], 1);
        step();
        iv[1] = 1'b0; orr[1] = 1'b0;
        chk("b2b_valid_low0", 1, ov[1], 0);
        step();
        chk("b2b_valid_low1", 1, ov[1], 0);
        step();
        chk("b2b_valid", 1, ov[1], 1);
        chk("b2b_data", 1, od[1], ref_sub(d2, 1'b1));
        chk("b2b_tag", 1, ot[1], t2);
        orr[1] = 1'b1;
        step();
        orr[1] = 1'b0;

        // Reset mid-computation on the single-lane instance.
        run_word(3, 48'h0123_4567_89AB, 4'hC, 1'b1);
        iv[3] = 1'b1; id[3] = {16'($urandom), $urandom}; it[3] = 4'hD;
        step();
        iv[3] = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 3, ov[3], 0);
        chk("midrst_data", 3, od[3], 0);
        chk("midrst_tag", 3, ot[3], 0);
        chk("midrst_ready", 3, ir[3], 1);
        #2;
        rst_n = 1'b1;
        step();
        chk("postrst_valid", 3, ov[3], 0);
        run_word(3, {16'($urandom), $urandom}, 4'h2, 1'b1);

        // Random traffic on every instance with a scoreboard queue.
        for (int k = 0; k < NI; k++) begin
            q_d.delete(); q_t.delete();
            pushed = 0; popped = 0;
            for (int c = 0; c < 200; c++) begin
                iv[k]  = ($urandom_range(0, 2) != 0);
                id[k]  = {16'($urandom), $urandom};
                it[k]  = 4'($urandom);
                orr[k] = 1'($urandom_range(0, 1));
                #1;
                if (ov[k] && orr[k]) begin
                    if (q_d.size() == 0) begin
                        chk("rnd_unexpected_out", k, 1, 0);
                    end else begin
                        pd = q_d.pop_front(); pt = q_t.pop_front(); popped++;
                        chk("rnd_data", k, od[k], pd);
                        chk("rnd_tag", k, ot[k], pt);
                    end
                end
                if (iv[k] && ir[k]) begin
                    q_d.push_back(ref_sub(id[k], fips_of(k)));
                    q_t.push_back(it[k]);
                    pushed++;
                end
                step();
            end
            iv[k] = 1'b0; orr[k] = 1'b1;
            for (int c = 0; c < 30; c++) begin
                #1;
                if (ov[k] && q_d.size() != 0) begin
                    pd = q_d.pop_front(); pt = q_t.pop_front(); popped++;
                    chk("drain_data", k, od[k], pd);
                    chk("drain_tag", k, ot[k], pt);
                end
                step();
            end
            orr[k] = 1'b0;
            chk("rnd_all_delivered", k, q_d.size(), 0);
            chk("rnd_counts", k, popped, pushed);
            chk("rnd_idle_end", k, ov[k], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_sbox_unit.md
Name: des_sbox_unit

Overview:
- Registered, parametrised DES S-box substitution layer for the pipelined DES datapath; successor to the standalone combinational 6→4 lookups.
- Maps the 48-bit post-key-mix word to the 32-bit pre-P word using S1..S8, evaluating LANES boxes per cycle. LANES trades area against latency.
- Valid/ready handshake on both sides, with a sideband tag carried through. Selectable FIPS row/column addressing or linear table addressing.

Parameters:
- LANES, 8, S-boxes evaluated per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
- FIPS_ADDR, 1, 1: row={x[5],x[0]}, col=x[4:1] (FIPS 46-3); 0: table index = x (linear, row-major).
- TAG_W, 4, width of the sideband tag passed from input to output unchanged.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word offered
- in_ready  out  1  unit can accept input
- in_data  in  48  S1 input = [47:42] … S8 input = [5:0]
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  32  S1 result = [31:28] … S8 result = [3:0]
- out_tag  out  TAG_W  tag of the word in out_data

Behaviour:
- Reset is asynchronous and active-low. Reset values: state=IDLE, out_valid=0, out_data=0, out_tag=0. in_ready is combinational and therefore 1 in IDLE.
- Define STEPS = 8/LANES.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept = in_valid & in_ready. On accept, capture in_data into a 48-bit work register and in_tag into a tag register, clear step counter, go to BUSY.
  - BUSY, each cycle: look up the LANES boxes indexed step*LANES .. step*LANES+LANES-1 (S1 first) from the top 6*LANES bits of the work register. Shift the work register left by 6*LANES. Shift the 4*LANES results into the low end of the accumulator. Increment step.
  - On the last BUSY step (step==STEPS-1): load out_data from the accumulator plus this step's results, load out_tag, set out_valid=1, go to DONE.
  - DONE: hold out_valid, out_data and out_tag stable until out_ready.
    - out_ready & in_valid: accept the new word in the same cycle, go to BUSY, out_valid=0.
    - out_ready & !in_valid: go to IDLE, out_valid=0.
  - out_data and out_tag keep the last result after the handshake completes. They change only when the next result is loaded.
- Latency: out_valid rises STEPS cycles after the accept edge (LANES=8 → 1 cycle; LANES=1 → 8 cycles).
- Maximum throughput: one word per STEPS+1 cycles, using back-to-back accept in DONE.
- in_data and in_tag are sampled only on the accept edge. Changes while BUSY have no effect.
- The step counter is $clog2(STEPS) bits wide, minimum 1 bit. It wraps to 0 on leaving BUSY.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values; the partial result is discarded and no output is produced.
- Tables: standard DES S1..S8 values per FIPS 46-3, 4 rows × 16 columns. In FIPS_ADDR=0 mode the same 64 entries are read at linear index x.

Decomposition:
- Package des_pkg contains:
  - the constant S-box table array SBOX[1:8][0:63] in row-major order;
  - the function sbox_index(x, fips) returning the 0..63 index;
  - the state enum {IDLE, BUSY, DONE}.
- Sub-module des_sbox_lut: combinational lookup with inputs box_sel[2:0], x[5:0] and parameter FIPS_ADDR, output y[3:0]. It is instantiated LANES times; lane i gets box_sel = step*LANES+i.

Test Plan:
- LANES=8, FIPS_ADDR=1, in_data=48'h0, out_ready=1 → out_data=32'hEFA72C4D, out_valid 1 cycle after accept, in_tag echoed on out_tag.
- LANES=2, in_data=48'hFFFFFFFFFFFF → out_data=32'hD9CE3DCB exactly 4 cycles after accept; in_ready=0 for those 4 cycles.
- LANES=8, S1 chunk 6'b011011, other chunks 0 → out_data[31:28]=4'h5. Repeat with FIPS_ADDR=0 and S1 chunk 6'b000001 → out_data[31:28]=4 (FIPS mode gives 0).
- LANES=4, hold out_ready=0 for 5 cycles in DONE → out_valid, out_data and out_tag stable. Then raise out_ready with in_valid=1 → next word accepted the same cycle and the next result appears 2 cycles later.
- LANES=1, pulse rst_n low during step 3 → out_valid=0, out_data=0, in_ready=1 immediately. The next word completes normally in 8 cycles.
- Random 48-bit words, all four LANES values, random in_valid/out_ready → out_data matches a des_pkg reference model, with no lost or duplicated words and tags in order.
